// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: 2-flop rx synchroniser, glitch-rejecting start detect, mid-bit sampling, stop check.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_deserializer #(
    parameter int DATA_W    = 8,
    parameter int OSR       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              rx,
    input  logic              parity_odd,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OSR - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t             state, state_n;
    logic               rx_meta, rx_s;
    logic [TW-1:0]      tick_cnt, tick_cnt_n;
    logic [BW-1:0]      bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]  shreg, shreg_n;
    logic               ferr_acc, ferr_acc_n;
    logic               done, done_ferr;
`ifdef UART_RX_PARITY_EN
    logic               perr_acc, perr_acc_n;
`else
    logic               unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // Everything advances only on an oversample tick; between ticks all state holds.
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        ferr_acc_n = ferr_acc;
        done       = 1'b0;
        done_ferr  = ferr_acc;
`ifdef UART_RX_PARITY_EN
        perr_acc_n = perr_acc;
`endif
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n    = S_START;
                        tick_cnt_n = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == HALF_LAST) begin
                        if (!rx_s) begin
                            state_n    = S_DATA;
                            tick_cnt_n = '0;
                            bit_cnt_n  = '0;
                            ferr_acc_n = 1'b0;
`ifdef UART_RX_PARITY_EN
                            perr_acc_n = 1'b0;
`endif
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == BIT_LAST) begin
                        shreg_n    = {rx_s, shreg[DATA_W-1:1]};
                        tick_cnt_n = '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                            state_n   = S_PARITY;
`else
                            state_n   = S_STOP;
`endif
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt == BIT_LAST) begin
                        perr_acc_n = ((^shreg) ^ rx_s) != parity_odd;
                        tick_cnt_n = '0;
                        state_n    = S_STOP;
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt_n = '0;
                        if (!rx_s) ferr_acc_n = 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            done      = 1'b1;
                            done_ferr = ferr_acc | ~rx_s;
                            bit_cnt_n = '0;
                            // A low line here is a break; park until it returns high.
                            state_n   = rx_s ? S_IDLE : S_BREAK;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ferr_acc  <= 1'b0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            ferr_acc <= ferr_acc_n;
            valid    <= done;
            if (done) begin
                data_out  <= shreg;
                frame_err <= done_ferr;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_acc   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            perr_acc <= perr_acc_n;
            if (done) parity_err <= perr_acc;
        end
    end
`endif

endmodule
